// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the multi-channel memory arbiter.
package mem_arb_pkg;

    // Memory request opcode as carried on the request channel.
    typedef enum logic {
        MEM_RD = 1'b0,
        MEM_WR = 1'b1
    } mem_op_e;

    // Arbiter transaction FSM.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WR   = 2'd2,
        ST_RD   = 2'd3
    } arb_state_e;

    // Width of a channel index; a single channel still gets one bit.
    function automatic int ch_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = ch_bits(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_oh,
    output logic [IW-1:0] gnt_idx
);

    // Scan N positions starting at ptr; the first asserted request wins.
    always_comb begin : scan
        logic [IW:0]   pos;
        logic [IW-1:0] idx;
        logic          found;
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            pos = {1'b0, ptr} + (IW+1)'(i);
            if (pos >= (IW+1)'(N)) begin
                pos = pos - (IW+1)'(N);
            end
            idx = pos[IW-1:0];
            if (!found && req[idx]) begin
                found       = 1'b1;
                gnt_oh[idx] = 1'b1;
                gnt_idx     = idx;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one VTAMemDPI request/write/read port among NUM_CH channels.
// Handshake rule: a beat or request transfers in a cycle where both its
// valid and its ready are high; valid, once raised, is held with stable
// payload until that cycle. mem_req_valid is the exception: it is a
// one-cycle pulse and the DPI side always takes it.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int NUM_CH        = 2,
    parameter  int MEM_LEN_BITS  = 8,
    parameter  int MEM_ADDR_BITS = 64,
    parameter  int MEM_DATA_BITS = 64,
    localparam int CH_BITS       = ch_bits(NUM_CH)
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic [NUM_CH-1:0]                       ch_req_valid,
    output logic [NUM_CH-1:0]                       ch_req_ready,
    input  logic [NUM_CH-1:0]                       ch_req_opcode,
    input  logic [NUM_CH-1:0][MEM_LEN_BITS-1:0]     ch_req_len,
    input  logic [NUM_CH-1:0][MEM_ADDR_BITS-1:0]    ch_req_addr,
    input  logic [NUM_CH-1:0]                       ch_wr_valid,
    output logic [NUM_CH-1:0]                       ch_wr_ready,
    input  logic [NUM_CH-1:0][MEM_DATA_BITS-1:0]    ch_wr_bits,
    output logic [NUM_CH-1:0]                       ch_rd_valid,
    input  logic [NUM_CH-1:0]                       ch_rd_ready,
    output logic [MEM_DATA_BITS-1:0]                ch_rd_bits,
    output logic                                    mem_req_valid,
    output logic                                    mem_req_opcode,
    output logic [MEM_LEN_BITS-1:0]                 mem_req_len,
    output logic [MEM_ADDR_BITS-1:0]                mem_req_addr,
    output logic                                    mem_wr_valid,
    output logic [MEM_DATA_BITS-1:0]                mem_wr_bits,
    input  logic                                    mem_rd_valid,
    input  logic [MEM_DATA_BITS-1:0]                mem_rd_bits,
    output logic                                    mem_rd_ready,
    output logic                                    busy,
    output logic [CH_BITS-1:0]                      grant
);

    arb_state_e               state_q, state_d;
    logic [CH_BITS-1:0]       grant_q, grant_d;
    logic [CH_BITS-1:0]       ptr_q, ptr_d;
    logic [MEM_LEN_BITS-1:0]  cnt_q, cnt_d;
    logic                     opcode_q, opcode_d;
    logic [MEM_LEN_BITS-1:0]  len_q, len_d;
    logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;

    logic [NUM_CH-1:0]        arb_oh;
    logic [CH_BITS-1:0]       arb_idx;

    rr_arbiter #(.N(NUM_CH)) u_rr (
        .req     (ch_req_valid),
        .ptr     (ptr_q),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx)
    );

    // Next-state, latch updates and channel/DPI steering for the current state.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        opcode_d     = opcode_q;
        len_d        = len_q;
        addr_d       = addr_q;
        ch_req_ready = '0;
        ch_wr_ready  = '0;
        ch_rd_valid  = '0;
        mem_wr_valid = 1'b0;
        mem_wr_bits  = '0;
        mem_rd_ready = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|ch_req_valid) begin
                    // The ready strobe is combinational, so it is masked while
                    // reset is held to keep every output quiet in reset.
                    ch_req_ready = arb_oh & {NUM_CH{reset}};
                    opcode_d     = ch_req_opcode[arb_idx];
                    len_d        = ch_req_len[arb_idx];
                    addr_d       = ch_req_addr[arb_idx];
                    grant_d      = arb_idx;
                    ptr_d        = (arb_idx == CH_BITS'(NUM_CH - 1)) ? '0 : arb_idx + CH_BITS'(1);
                    state_d      = ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_d   = '0;
                state_d = (opcode_q == MEM_WR) ? ST_WR : ST_RD;
            end
            ST_WR: begin
                ch_wr_ready[grant_q] = 1'b1;
                mem_wr_valid         = ch_wr_valid[grant_q];
                mem_wr_bits          = ch_wr_bits[grant_q];
                if (ch_wr_valid[grant_q]) begin
                    cnt_d = cnt_q + MEM_LEN_BITS'(1);
                    if (cnt_q == len_q) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RD: begin
                ch_rd_valid[grant_q] = mem_rd_valid;
                mem_rd_ready         = ch_rd_ready[grant_q];
                if (mem_rd_valid && ch_rd_ready[grant_q]) begin
                    cnt_d = cnt_q + MEM_LEN_BITS'(1);
                    if (cnt_q == len_q) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, grant/pointer, beat counter and latched request registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            opcode_q <= 1'b0;
            len_q    <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            opcode_q <= opcode_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
        end
    end

    assign mem_req_valid  = (state_q == ST_REQ);
    assign mem_req_opcode = opcode_q;
    assign mem_req_len    = len_q;
    assign mem_req_addr   = addr_q;
    assign busy           = (state_q != ST_IDLE);
    assign grant          = grant_q;
    assign ch_rd_bits     = mem_rd_bits;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with NUM_CH=2: a cycle table for two
// back-to-back write bursts, then read backpressure, round-robin fairness
// and reset-mid-burst sequences.
module tb_mem_arbiter;

    logic                 clock;
    logic                 reset;
    logic [1:0]           ch_req_valid;
    logic [1:0]           ch_req_ready;
    logic [1:0]           ch_req_opcode;
    logic [1:0][7:0]      ch_req_len;
    logic [1:0][63:0]     ch_req_addr;
    logic [1:0]           ch_wr_valid;
    logic [1:0]           ch_wr_ready;
    logic [1:0][63:0]     ch_wr_bits;
    logic [1:0]           ch_rd_valid;
    logic [1:0]           ch_rd_ready;
    logic [63:0]          ch_rd_bits;
    logic                 mem_req_valid;
    logic                 mem_req_opcode;
    logic [7:0]           mem_req_len;
    logic [63:0]          mem_req_addr;
    logic                 mem_wr_valid;
    logic [63:0]          mem_wr_bits;
    logic                 mem_rd_valid;
    logic [63:0]          mem_rd_bits;
    logic                 mem_rd_ready;
    logic                 busy;
    logic [0:0]           grant;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    mem_arbiter #(
        .NUM_CH(2), .MEM_LEN_BITS(8), .MEM_ADDR_BITS(64), .MEM_DATA_BITS(64)
    ) dut (
        .clock(clock), .reset(reset),
        .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready),
        .ch_req_opcode(ch_req_opcode), .ch_req_len(ch_req_len), .ch_req_addr(ch_req_addr),
        .ch_wr_valid(ch_wr_valid), .ch_wr_ready(ch_wr_ready), .ch_wr_bits(ch_wr_bits),
        .ch_rd_valid(ch_rd_valid), .ch_rd_ready(ch_rd_ready), .ch_rd_bits(ch_rd_bits),
        .mem_req_valid(mem_req_valid), .mem_req_opcode(mem_req_opcode),
        .mem_req_len(mem_req_len), .mem_req_addr(mem_req_addr),
        .mem_wr_valid(mem_wr_valid), .mem_wr_bits(mem_wr_bits),
        .mem_rd_valid(mem_rd_valid), .mem_rd_bits(mem_rd_bits), .mem_rd_ready(mem_rd_ready),
        .busy(busy), .grant(grant)
    );

    // Clock: 10-unit period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  req_v;
        logic [1:0]  wr_v;
        logic [63:0] wr0;
        logic [63:0] wr1;
        logic [1:0]  e_req_rdy;
        logic        e_mreq_v;
        logic [7:0]  e_len;
        logic [63:0] e_addr;
        logic        e_mwr_v;
        logic [63:0] e_mwr_bits;
        logic [1:0]  e_wr_rdy;
        logic        e_busy;
        logic        e_grant;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ch_req_ready"}, ch_req_ready, 0);
        chk({tag, "_ch_wr_ready"}, ch_wr_ready, 0);
        chk({tag, "_ch_rd_valid"}, ch_rd_valid, 0);
        chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
        chk({tag, "_mem_req_opcode"}, mem_req_opcode, 0);
        chk({tag, "_mem_req_len"}, mem_req_len, 0);
        chk({tag, "_mem_req_addr"}, mem_req_addr, 0);
        chk({tag, "_mem_wr_valid"}, mem_wr_valid, 0);
        chk({tag, "_mem_wr_bits"}, mem_wr_bits, 0);
        chk({tag, "_mem_rd_ready"}, mem_rd_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_grant"}, grant, 0);
    endtask

    // One read-phase cycle on channel 1: drive DPI beat and channel readiness,
    // check steering, and score any completed beat.
    task automatic rd_cycle(input logic v, input logic [63:0] bits, input logic [1:0] rdy);
        @(posedge clock); #1;
        mem_rd_valid = v;
        mem_rd_bits  = bits;
        ch_rd_ready  = rdy;
        @(negedge clock);
        chk("rd_ch0_valid", ch_rd_valid[0], 0);
        chk("rd_ch1_valid", ch_rd_valid[1], v);
        chk("rd_mem_ready", mem_rd_ready, rdy[1]);
        chk("rd_bits_bcast", ch_rd_bits, bits);
        if (ch_rd_valid[1] && ch_rd_ready[1]) begin
            if (exp_q.size() == 0) begin
                chk("rd_unexpected_beat", 1, 0);
            end else begin
                chk("rd_beat_data", ch_rd_bits, exp_q.pop_front());
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clock);
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk("wait_idle_timeout", busy, 0);
    endtask

    initial begin
        int pulses;
        int last_cyc;

        vecs[0]  = '{2'b01, 2'b10, 64'h0,  64'hB0, 2'b01, 1'b0, 8'd0, 64'h0,    1'b0, 64'h0,  2'b00, 1'b0, 1'b0};
        vecs[1]  = '{2'b10, 2'b10, 64'h0,  64'hB0, 2'b00, 1'b1, 8'd3, 64'h1000, 1'b0, 64'h0,  2'b00, 1'b1, 1'b0};
        vecs[2]  = '{2'b10, 2'b11, 64'hA0, 64'hB0, 2'b00, 1'b0, 8'd0, 64'h0,    1'b1, 64'hA0, 2'b01, 1'b1, 1'b0};
        vecs[3]  = '{2'b10, 2'b10, 64'hA1, 64'hB0, 2'b00, 1'b0, 8'd0, 64'h0,    1'b0, 64'hA1, 2'b01, 1'b1, 1'b0};
        vecs[4]  = '{2'b10, 2'b11, 64'hA1, 64'hB0, 2'b00, 1'b0, 8'd0, 64'h0,    1'b1, 64'hA1, 2'b01, 1'b1, 1'b0};
        vecs[5]  = '{2'b10, 2'b11, 64'hA2, 64'hB0, 2'b00, 1'b0, 8'd0, 64'h0,    1'b1, 64'hA2, 2'b01, 1'b1, 1'b0};
        vecs[6]  = '{2'b10, 2'b11, 64'hA3, 64'hB0, 2'b00, 1'b0, 8'd0, 64'h0,    1'b1, 64'hA3, 2'b01, 1'b1, 1'b0};
        vecs[7]  = '{2'b10, 2'b10, 64'h0,  64'hB0, 2'b10, 1'b0, 8'd0, 64'h0,    1'b0, 64'h0,  2'b00, 1'b0, 1'b0};
        vecs[8]  = '{2'b00, 2'b10, 64'h0,  64'hB0, 2'b00, 1'b1, 8'd1, 64'h2000, 1'b0, 64'h0,  2'b00, 1'b1, 1'b1};
        vecs[9]  = '{2'b00, 2'b10, 64'h0,  64'hB0, 2'b00, 1'b0, 8'd0, 64'h0,    1'b1, 64'hB0, 2'b10, 1'b1, 1'b1};
        vecs[10] = '{2'b00, 2'b10, 64'h0,  64'hB1, 2'b00, 1'b0, 8'd0, 64'h0,    1'b1, 64'hB1, 2'b10, 1'b1, 1'b1};
        vecs[11] = '{2'b00, 2'b00, 64'h0,  64'h0,  2'b00, 1'b0, 8'd0, 64'h0,    1'b0, 64'h0,  2'b00, 1'b0, 1'b1};

        // Reset with both channels requesting: nothing may leak out.
        reset         = 1'b0;
        ch_req_valid  = 2'b11;
        ch_req_opcode = 2'b11;
        ch_req_len    = '0;
        ch_req_addr   = '0;
        ch_wr_valid   = '0;
        ch_wr_bits    = '0;
        ch_rd_ready   = '0;
        mem_rd_valid  = 1'b0;
        mem_rd_bits   = '0;
        @(negedge clock);
        chk_quiet("por");
        @(posedge clock); #1;
        reset        = 1'b1;
        ch_req_valid = 2'b00;
        ch_req_len[0]  = 8'd3;
        ch_req_addr[0] = 64'h1000;
        ch_req_len[1]  = 8'd1;
        ch_req_addr[1] = 64'h2000;

        // Write bursts: ch0 len 3, ch1 stalled behind it then served.
        for (int i = 0; i < NV; i++) begin
            @(posedge clock); #1;
            ch_req_valid  = vecs[i].req_v;
            ch_wr_valid   = vecs[i].wr_v;
            ch_wr_bits[0] = vecs[i].wr0;
            ch_wr_bits[1] = vecs[i].wr1;
            @(negedge clock);
            chk($sformatf("v%0d_ch_req_ready", i), ch_req_ready, vecs[i].e_req_rdy);
            chk($sformatf("v%0d_mem_req_valid", i), mem_req_valid, vecs[i].e_mreq_v);
            chk($sformatf("v%0d_mem_wr_valid", i), mem_wr_valid, vecs[i].e_mwr_v);
            chk($sformatf("v%0d_mem_wr_bits", i), mem_wr_bits, vecs[i].e_mwr_bits);
            chk($sformatf("v%0d_ch_wr_ready", i), ch_wr_ready, vecs[i].e_wr_rdy);
            chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("v%0d_grant", i), grant, vecs[i].e_grant);
            chk($sformatf("v%0d_ch_rd_valid", i), ch_rd_valid, 0);
            if (vecs[i].e_mreq_v) begin
                chk($sformatf("v%0d_mem_req_opcode", i), mem_req_opcode, 1);
                chk($sformatf("v%0d_mem_req_len", i), mem_req_len, vecs[i].e_len);
                chk($sformatf("v%0d_mem_req_addr", i), mem_req_addr, vecs[i].e_addr);
            end
        end

        // ch1 read len 1 with two stall cycles on the first beat.
        @(posedge clock); #1;
        ch_req_opcode  = 2'b00;
        ch_req_addr[1] = 64'h3000;
        ch_req_valid   = 2'b10;
        @(negedge clock);
        chk("rd_accept", ch_req_ready, 2'b10);
        @(posedge clock); #1;
        ch_req_valid = 2'b00;
        @(negedge clock);
        chk("rd_req_pulse", mem_req_valid, 1);
        chk("rd_req_opcode", mem_req_opcode, 0);
        chk("rd_req_len", mem_req_len, 1);
        chk("rd_req_addr", mem_req_addr, 64'h3000);
        chk("rd_grant", grant, 1);
        exp_q.push_back(64'h11);
        exp_q.push_back(64'h22);
        rd_cycle(1'b1, 64'h11, 2'b01);
        rd_cycle(1'b1, 64'h11, 2'b01);
        rd_cycle(1'b1, 64'h11, 2'b10);
        rd_cycle(1'b1, 64'h22, 2'b10);
        @(posedge clock); #1;
        mem_rd_valid = 1'b0;
        ch_rd_ready  = 2'b00;
        @(negedge clock);
        chk("rd_done_busy", busy, 0);
        chk("rd_beats_left", exp_q.size(), 0);

        // Both channels request len-0 reads back to back: grants alternate.
        @(posedge clock); #1;
        ch_req_len   = '0;
        ch_req_valid = 2'b11;
        mem_rd_valid = 1'b1;
        mem_rd_bits  = 64'h55;
        ch_rd_ready  = 2'b11;
        pulses   = 0;
        last_cyc = 0;
        for (int c = 0; c < 40 && pulses < 4; c++) begin
            if (c > 0) @(negedge clock);
            else @(negedge clock);
            if (mem_req_valid) begin
                chk($sformatf("alt_grant%0d", pulses), grant, pulses % 2);
                if (pulses > 0) chk($sformatf("alt_gap%0d_ge3", pulses), (c - last_cyc) >= 3, 1);
                last_cyc = c;
                pulses++;
                if (pulses == 4) ch_req_valid = 2'b00;
            end
        end
        chk("alt_pulse_count", pulses, 4);
        wait_idle(20);

        // ch0 read of 5 beats, reset after 2 beats.
        @(posedge clock); #1;
        ch_req_valid   = 2'b01;
        ch_req_len[0]  = 8'd4;
        ch_req_addr[0] = 64'h4000;
        ch_rd_ready    = 2'b01;
        mem_rd_bits    = 64'h77;
        @(negedge clock);
        chk("rst_seq_accept", ch_req_ready, 2'b01);
        @(posedge clock); #1;
        ch_req_valid = 2'b00;
        @(negedge clock);
        chk("rst_seq_pulse", mem_req_valid, 1);
        for (int b = 0; b < 2; b++) begin
            @(posedge clock); #1;
            @(negedge clock);
            chk($sformatf("rst_seq_beat%0d", b), ch_rd_valid & ch_rd_ready, 2'b01);
        end
        @(posedge clock); #1;
        reset        = 1'b0;
        ch_req_valid = 2'b11;
        @(negedge clock);
        chk_quiet("midrst_a");
        @(negedge clock);
        chk_quiet("midrst_b");
        @(posedge clock); #1;
        reset       = 1'b1;
        ch_req_len  = '0;
        @(negedge clock);
        chk("post_rst_accept", ch_req_ready, 2'b01);
        @(posedge clock); #1;
        ch_req_valid = 2'b00;
        @(negedge clock);
        chk("post_rst_pulse", mem_req_valid, 1);
        chk("post_rst_grant", grant, 0);
        wait_idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
